// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation codes, FSM states
// and small decode helpers used by the top level and the ALU decoder.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    function automatic logic is_shift_code(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter. Loaded with a value and amount, it
// shifts until its count reaches zero; last_o flags the final shift step.
module alu_shift_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               dir_right_i,
    input  logic               arith_i,
    input  logic [SHAMT_W-1:0] amount_i,
    input  logic [WIDTH-1:0]   value_i,
    output logic               last_o,
    output logic [WIDTH-1:0]   value_o
);

    logic [WIDTH-1:0]   shreg_q;
    logic [SHAMT_W-1:0] count_q;
    logic               dir_right_q;
    logic               arith_q;
    logic [WIDTH-1:0]   step_value;

    // Fill bit for right shifts is the sign only for arithmetic shifts.
    always_comb begin
        if (dir_right_q) begin
            step_value = {arith_q & shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
        end else begin
            step_value = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q     <= '0;
            count_q     <= '0;
            dir_right_q <= 1'b0;
            arith_q     <= 1'b0;
        end else if (load_i) begin
            shreg_q     <= value_i;
            count_q     <= amount_i;
            dir_right_q <= dir_right_i;
            arith_q     <= arith_i;
        end else if (count_q != '0) begin
            shreg_q <= step_value;
            count_q <= count_q - SHAMT_W'(1);
        end
    end

    assign last_o  = (count_q == SHAMT_W'(1));
    assign value_o = step_value;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake: single-cycle logic and
// arithmetic ops, iterative shifts sequenced through alu_shift_iter.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               illegal_q, illegal_d;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_illegal;
    logic               accept;
    logic [SHAMT_W-1:0] amount;
    logic               shift_load;
    logic               sh_last;
    logic [WIDTH-1:0]   sh_value;

    assign accept     = in_valid && in_ready;
    assign amount     = op_b[SHAMT_W-1:0];
    assign shift_load = accept && is_shift_code(alu_ctrl) && (amount != '0);

    // Shift codes fall through to op_a here, which is the zero-amount result.
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (alu_ctrl)
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_XOR: alu_res = op_a ^ op_b;
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
            default: alu_illegal = 1'b1;
        endcase
    end

    alu_shift_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (shift_load),
        .dir_right_i (alu_ctrl != ALU_SLL),
        .arith_i     (alu_ctrl == ALU_SRA),
        .amount_i    (amount),
        .value_i     (op_a),
        .last_o      (sh_last),
        .value_o     (sh_value)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    illegal_d = alu_illegal;
                    if (shift_load) begin
                        state_d = S_SHIFT;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (sh_last) begin
                    result_d = sh_value;
                    zero_d   = (sh_value == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    // in_ready is gated by rst_n so nothing is accepted while reset is held.
    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: result, illegal flag and number of edges after the
    // accept edge before out_valid is visible.
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        int n;
        n   = int'(b[4:0]);
        r   = 32'h0;
        ill = 1'b0;
        lat = 0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0011: r = a ^ b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: begin r = a << n; lat = n; end
            4'b1001: begin r = a >> n; lat = n; end
            4'b1010: begin r = $signed(a) >>> n; lat = n; end
            default: ill = 1'b1;
        endcase
    endfunction

    // One full transaction; holdCycles > 0 applies backpressure in DONE.
    task automatic applyStimulus(input string tag, input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input int holdCycles);
        logic [31:0] expRes;
        logic        expIll;
        int          expLat;
        int          edges;
        model(c, a, b, expRes, expIll, expLat);
        checkOutput({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        alu_ctrl  = c;
        op_a      = a;
        op_b      = b;
        out_ready = (holdCycles == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        edges    = 0;
        while (!out_valid && edges < 64) begin
            checkOutput({tag, ".busy_shift"}, 32'(busy), 32'd1);
            checkOutput({tag, ".in_ready_shift"}, 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput({tag, ".latency"}, 32'(edges), 32'(expLat));
        checkOutput({tag, ".result"}, result, expRes);
        checkOutput({tag, ".zero"}, 32'(zero), 32'(expRes == 32'h0));
        checkOutput({tag, ".illegal"}, 32'(illegal), 32'(expIll));
        checkOutput({tag, ".busy_done"}, 32'(busy), 32'd1);
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, ".hold_result"}, result, expRes);
            checkOutput({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ".busy_idle"}, 32'(busy), 32'd0);
        checkOutput({tag, ".kept_result"}, result, expRes);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".result"}, result, 32'h0);
        checkOutput({tag, ".zero"}, 32'(zero), 32'd0);
        checkOutput({tag, ".illegal"}, 32'(illegal), 32'd0);
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic releaseReset(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [3:0] codes [9];
        logic [3:0] c;
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0011, 4'b0111, 4'b1000, 4'b1001, 4'b1010};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_ctrl  = 4'h0;
        op_a      = 32'h0;
        op_b      = 32'h0;
        out_ready = 1'b1;
        #3;
        checkResetOutputs("rst0");
        repeat (2) @(posedge clk);
        releaseReset("rst0");

        applyStimulus("add", 4'b0010, 32'd5, 32'd7, 0);
        applyStimulus("sub_zero", 4'b0110, 32'd9, 32'd9, 0);
        applyStimulus("sub_wrap", 4'b0110, 32'd0, 32'd1, 0);
        applyStimulus("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
        applyStimulus("slt_pos", 4'b0111, 32'd1, 32'hFFFF_FFFF, 0);
        applyStimulus("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 0);
        applyStimulus("or", 4'b0001, 32'hA000_0001, 32'h0500_0010, 0);
        applyStimulus("xor", 4'b0011, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        applyStimulus("sll4", 4'b1000, 32'h1, 32'd4, 0);
        applyStimulus("sra31", 4'b1010, 32'h8000_0000, 32'd31, 0);
        applyStimulus("srl_hibits", 4'b1001, 32'h8000_0000, 32'hFFFF_FFE3, 0);
        applyStimulus("shift0", 4'b1001, 32'h1234_5678, 32'h0000_0020, 0);
        applyStimulus("backpressure", 4'b0010, 32'h1000_0000, 32'h0000_0ABC, 5);
        applyStimulus("illegal", 4'b1111, 32'h55, 32'h66, 0);
        applyStimulus("legal_after_illegal", 4'b0001, 32'h3, 32'h4, 0);

        // Abort an SRL of 20 once ten shifts remain.
        applyStimulus("pre_abort", 4'b0010, 32'd40, 32'd2, 0);
        in_valid = 1'b1;
        alu_ctrl = 4'b1001;
        op_a     = 32'hCAFE_F00D;
        op_b     = 32'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_mid_shift");
        repeat (2) @(posedge clk);
        releaseReset("rst_mid_shift");
        applyStimulus("add_after_abort", 4'b0010, 32'd100, 32'd23, 0);
        applyStimulus("sll_after_abort", 4'b1000, 32'h3, 32'd3, 0);

        // Reset while an illegal result is held under backpressure.
        in_valid  = 1'b1;
        alu_ctrl  = 4'b1100;
        op_a      = 32'h1;
        op_b      = 32'h1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("held_illegal.valid", 32'(out_valid), 32'd1);
        checkOutput("held_illegal.zero", 32'(zero), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rst_in_done");
        out_ready = 1'b1;
        releaseReset("rst_in_done");

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                c = 4'($urandom);
            end else begin
                c = codes[$urandom_range(0, 8)];
            end
            applyStimulus($sformatf("rand%0d", i), c, $urandom, $urandom, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
